// File: rtl/debug_mailbox_ctrl_pkg.sv
// debug_pkg: shared states, function codes and sizes for the debug mailbox
package debug_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_PRINT, ST_HALT} dbg_state_t;
  localparam int DBG_HALT      = 0;
  localparam int DBG_ASSERT_EQ = 1;
  localparam int DBG_ASSERT_NE = 2;
  localparam int DBG_PRINT     = 3;
  localparam int DBG_ARGS      = 8;
endpackage

// File: rtl/debug_mailbox_ctrl_if.sv
// debug_mailbox_ctrl_if: core write/read port plus the serial byte stream
interface debug_mailbox_ctrl_if #(parameter int DATA_W = 32);
  logic              we;
  logic [2:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        raddr;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  modport master (output we, addr, wdata, raddr, tx_ready, input rdata, stall, tx_data, tx_valid);
  modport slave  (input we, addr, wdata, raddr, tx_ready, output rdata, stall, tx_data, tx_valid);
endinterface

// File: rtl/debug_mailbox_ctrl_sat_counter.sv
// sat_counter: counter advancing by 0, 1 or 2 per cycle, clamped at all-ones
module sat_counter #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W:0] sum;
  assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
endmodule

// File: rtl/debug_mailbox_ctrl.sv
// debug_mailbox_ctrl: latches mailbox commands, stalls the core and executes halt/assert/print
module debug_mailbox_ctrl
  import debug_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  debug_mailbox_ctrl_if.slave  bus,
  output logic                 halted,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 fail_pulse
);
  dbg_state_t        state;
  logic [1:0]        idx;
  logic [DATA_W-1:0] args [DBG_ARGS];
  logic [7:0]        cur;
  logic              eq, exec_pass, exec_fail, overrun;
  logic [1:0]        pass_inc, fail_inc;
  // args[0] keeps the function code, so EXEC decodes it straight from storage
  assign cur       = args[1][{idx, 3'b000} +: 8];
  assign eq        = args[1] == args[2];
  assign exec_pass = state == ST_EXEC &&
                     ((args[0] == DATA_W'(DBG_ASSERT_EQ) && eq) || (args[0] == DATA_W'(DBG_ASSERT_NE) && !eq));
  assign exec_fail = state == ST_EXEC && !exec_pass;
  assign overrun   = bus.we && state != ST_IDLE;
  assign pass_inc  = {1'b0, exec_pass};
  assign fail_inc  = {1'b0, overrun} + {1'b0, exec_fail};
  assign bus.rdata    = args[bus.raddr];
  assign bus.stall    = state != ST_IDLE;
  assign bus.tx_valid = state == ST_PRINT && cur != 8'h00;
  assign bus.tx_data  = state == ST_PRINT ? cur : 8'h00;
  assign halted       = state == ST_HALT;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      fail_pulse <= 1'b0;
      for (int i = 0; i < DBG_ARGS; i++) args[i] <= '0;
    end else begin
      fail_pulse <= |fail_inc;
      case (state)
        ST_IDLE: if (bus.we) begin
          args[bus.addr] <= bus.wdata;
          if (bus.addr == 3'd0) begin
            idx   <= '0;
            state <= bus.wdata == DATA_W'(DBG_HALT)  ? ST_HALT :
                     bus.wdata == DATA_W'(DBG_PRINT) ? ST_PRINT : ST_EXEC;
          end
        end
        ST_EXEC:  state <= ST_IDLE;
        ST_PRINT: if (cur == 8'h00 || (bus.tx_ready && idx == 2'd3)) state <= ST_IDLE;
                  else if (bus.tx_ready) idx <= idx + 2'd1;
        default:  state <= ST_HALT;
      endcase
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_pass (.clk(clk), .reset(reset), .inc(pass_inc), .cnt(pass_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_fail (.clk(clk), .reset(reset), .inc(fail_inc), .cnt(fail_cnt));
endmodule
